// File: rtl/sc_serial_pkg.sv
// sc_serial_pkg: shared states and sizing helpers for the serial transmitter
package sc_serial_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  function automatic int frame_len(input int width, input int parity);
    return width + (parity != 0 ? 1 : 0);
  endfunction
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/sc_serial_shreg.sv
// sc_serial_shreg: loadable shift register whose head flop drives the serial line
module sc_serial_shreg #(
  parameter int WIDTH = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] din,
  output logic             head
);
  logic [WIDTH-1:0] q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= (MSB_FIRST != 0) ? {q[WIDTH-2:0], shift_in} : {shift_in, q[WIDTH-1:1]};
  assign head = (MSB_FIRST != 0) ? q[WIDTH-1] : q[0];
endmodule

// File: rtl/sc_serial_tx.sv
// sc_serial_tx: valid/ready parallel-to-serial transmitter with optional even parity
module sc_serial_tx import sc_serial_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY = 0
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             SDO,
  output logic             SFRAME,
  output logic             BUSY
);
  localparam int N = frame_len(WIDTH, PARITY);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic par, last, accept, shift_in;
  assign last = state == SHIFT && cnt == LAST;
  assign DIN_READY = RN && (state == IDLE || last);
  assign accept = DIN_VALID && DIN_READY;
  always_comb begin
    state_nx = accept ? SHIFT : last ? IDLE : state;
    cnt_nx = (accept || last) ? '0 : state == SHIFT ? cnt + CW'(1) : cnt;
  end
  always_ff @(posedge CLK or negedge RN)
    if (!RN) begin
      state <= IDLE;
      cnt <= '0;
      par <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept) par <= ^DIN;
    end
  // parity enters the tail on the first shift and reaches the head right after the last data bit
  assign shift_in = PARITY != 0 && cnt == '0 && par;
  sc_serial_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shreg (
    .clk(CLK),
    .rst_n(RN),
    .load(accept),
    .shift(state == SHIFT),
    .shift_in(shift_in),
    .din(DIN),
    .head(SDO)
  );
  assign SFRAME = state == SHIFT;
  assign BUSY = SFRAME;
endmodule

// File: tb/tb_sc_serial_tx.sv
// tb_sc_serial_tx: queue-model bench for two transmitter configurations
module tb_sc_serial_tx;
  logic clk = 1'b0, rn, va, vb;
  logic [7:0] din;
  logic ra, sa, fa, ba, rb, sb, fb, bb;
  int checks = 0, failures = 0;
  bit qa[$], qb[$];
  bit acc_a, acc_b;
  logic [15:0] cap;
  int cnt_f;

  always #5 clk = ~clk;

  sc_serial_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY(0)) dut_a (
    .CLK(clk), .RN(rn), .DIN(din), .DIN_VALID(va),
    .DIN_READY(ra), .SDO(sa), .SFRAME(fa), .BUSY(ba));
  sc_serial_tx #(.WIDTH(8), .MSB_FIRST(0), .PARITY(1)) dut_b (
    .CLK(clk), .RN(rn), .DIN(din), .DIN_VALID(vb),
    .DIN_READY(rb), .SDO(sb), .SFRAME(fb), .BUSY(bb));

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
    end
  endtask

  // model: each queue holds the bits still to appear on the line, head = current bit
  always @(posedge clk or negedge rn)
    if (!rn) begin
      qa.delete();
      qb.delete();
    end else begin
      acc_a = va && qa.size() <= 1;
      acc_b = vb && qb.size() <= 1;
      if (qa.size() > 0) void'(qa.pop_front());
      if (qb.size() > 0) void'(qb.pop_front());
      if (acc_a) for (int i = 0; i < 8; i++) qa.push_back(din[7-i]);
      if (acc_b) begin
        for (int i = 0; i < 8; i++) qb.push_back(din[i]);
        qb.push_back(^din);
      end
    end

  always @(negedge clk) begin
    chk("a_sdo", sa, qa.size() > 0 ? qa[0] : 1'b0);
    chk("a_sframe", fa, qa.size() > 0);
    chk("a_busy", ba, qa.size() > 0);
    chk("a_ready", ra, rn && qa.size() <= 1);
    chk("b_sdo", sb, qb.size() > 0 ? qb[0] : 1'b0);
    chk("b_sframe", fb, qb.size() > 0);
    chk("b_busy", bb, qb.size() > 0);
    chk("b_ready", rb, rn && qb.size() <= 1);
  end

  task automatic pulse(input logic [7:0] w, input bit to_a);
    @(posedge clk);
    #1 din = w;
    if (to_a) va = 1'b1; else vb = 1'b1;
    @(posedge clk);
    #1 va = 1'b0;
    vb = 1'b0;
  endtask

  initial begin
    rn = 1'b0; va = 1'b0; vb = 1'b0; din = 8'h00;
    #1;
    chk("rst_ready", ra, 0);
    chk("rst_sdo", sa, 0);
    chk("rst_sframe", fa, 0);
    repeat (3) @(negedge clk);
    #2 rn = 1'b1;
    #1 chk("rel_ready", ra, 1);
    repeat (5) @(negedge clk);
    chk("stall_sframe", fa, 0);
    chk("stall_ready", rb, 1);
    // MSB-first word; DIN scrambled mid-frame must not matter
    pulse(8'hA5, 1'b1);
    cap = '0; cnt_f = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 8) cap = {cap[14:0], sa};
      cnt_f += int'(fa);
      if (i == 3) din = 8'h3C;
    end
    chk("a5_bits", cap[7:0], 8'hA5);
    chk("a5_frame_len", cnt_f, 8);
    // LSB-first with parity
    pulse(8'h07, 1'b0);
    cap = '0; cnt_f = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 9) cap[i] = sb;
      cnt_f += int'(fb);
    end
    chk("07_bits", cap[8:0], 9'h107);
    chk("07_frame_len", cnt_f, 9);
    // back-to-back with DIN_VALID held high
    @(posedge clk);
    #1 din = 8'hFF; va = 1'b1;
    @(posedge clk);
    #1 din = 8'h00;
    cap = '0; cnt_f = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i < 16) cap = {cap[14:0], sa};
      cnt_f += int'(fa);
      if (i == 8) va = 1'b0;
    end
    chk("b2b_bits", cap, 16'hFF00);
    chk("b2b_frame_len", cnt_f, 16);
    // reset mid-frame, seen without a clock edge
    pulse(8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    #2 rn = 1'b0;
    #1;
    chk("mid_rst_sframe", fa, 0);
    chk("mid_rst_ready", ra, 0);
    chk("mid_rst_sdo", sa, 0);
    repeat (3) @(negedge clk);
    #2 rn = 1'b1;
    pulse(8'h81, 1'b1);
    cap = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 8) cap = {cap[14:0], sa};
    end
    chk("81_bits", cap[7:0], 8'h81);
    chk("end_idle", fa, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
